pkt_decision_ctrl: RTL
======================

// Module: pkt_decision_ctrl
// PURPOSE
//  Per-packet forwarding sequencer in the router output-port-lookup path. Pairs the
//  front of the pktstate FIFO (from-CPU flag) with the front of the lookup-result FIFO.
//  Decides forward, punt-to-CPU or drop. Then streams the buffered packet from the
//  packet FIFO to the master AXIS port, rewriting the tuser dst-port field, or discards it.
// PARAMETERS
//  C_S_AXIS_DATA_WIDTH   256  tdata width; tkeep = /8
//  C_S_AXIS_TUSER_WIDTH  128  tuser width
//  SRC_PORT_OFF          16   lsb of 8-bit one-hot src-port field in tuser
//  DST_PORT_OFF          24   lsb of 8-bit one-hot dst-port field in tuser
// PORTS
//  clk               in   1    clock
//  reset             in   1    synchronous, active-high reset
//  i_pktstate_valid  in   1    pktstate FIFO not empty
//  i_pkt_is_from_cpu in   1    pktstate FIFO head: packet came from a CPU port
//  o_rd_pktstate     out  1    pop pulse to pktstate FIFO
//  i_lookup_valid    in   1    lookup-result FIFO not empty
//  i_lookup_hit      in   1    head: route/ARP hit
//  i_lookup_drop     in   1    head: drop (TTL expired, bad checksum, ...)
//  i_lookup_port     in   8    head: one-hot egress port on hit
//  o_rd_lookup       out  1    pop pulse to lookup-result FIFO
//  i_fifo_empty      in   1    packet FIFO (fallthrough) empty
//  i_fifo_tdata/tkeep/tuser/tlast  in  DW/DW/8/TW/1  packet FIFO head beat
//  o_fifo_rd_en      out  1    pop one beat from packet FIFO
//  m_axis_tdata/tkeep/tuser/tlast  out DW/DW/8/TW/1  egress beat
//  m_axis_tvalid     out  1    egress valid
//  m_axis_tready     in   1    egress ready
//  o_stat_fwd/o_stat_cpu/o_stat_drop  out  32 each  decision counters (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: state=WAIT; o_rd_pktstate, o_rd_lookup, o_fifo_rd_en, m_axis_tvalid = 0.
//    Counters = 0. A reset mid-packet abandons it. Upstream FIFOs share the reset.
//  - Every packet produces exactly one pktstate entry and one lookup entry, including
//    from-CPU packets. Both are always popped together.
//  - States:
//    WAIT: if i_pktstate_valid & i_lookup_valid & !i_fifo_empty, then for 1 cycle
//      o_rd_pktstate=o_rd_lookup=1. Latch dst/decision. Next state is SEND or DROP.
//      Otherwise stay in WAIT.
//    SEND: m_axis_tvalid = !i_fifo_empty; o_fifo_rd_en = m_axis_tvalid & m_axis_tready.
//      On a transferred beat with tlast=1, go to WAIT. tvalid never depends on tready.
//    DROP: o_fifo_rd_en = !i_fifo_empty. On a popped beat with tlast=1, go to WAIT.
//      Nothing is presented on m_axis.
//  - Decision, evaluated in priority order:
//    from_cpu -> SEND, dst unchanged.
//    else drop -> DROP.
//    else hit -> SEND, dst = i_lookup_port.
//    else -> SEND, dst = src<<1 (punt to paired CPU port; src on even bits).
//    hit with i_lookup_port==0 is treated as drop.
//  - tuser[DST_PORT_OFF+:8] is rewritten on the first beat only. All other fields and
//    beats pass through unmodified. tdata/tkeep/tlast are combinational from the FIFO head.
//  - Latency: decision in WAIT cycle N; first egress beat valid in N+1; min 1 idle
//    cycle between packets.
//  - A single-beat packet (tlast on first beat) returns to WAIT after that one beat.
//  - Backpressure: m_axis_tready low holds the beat stable. The packet FIFO is not popped.
// CONFIGURATION
//  - DECISION_STATS_EN defined:
//    o_stat_fwd counts SEND decisions with a lookup hit or from-CPU.
//    o_stat_cpu counts miss/punt decisions. o_stat_drop counts DROP decisions.
//    Each increments in the WAIT decision cycle. Counters wrap 0xFFFFFFFF->0.
//  - DECISION_STATS_EN undefined: counters are not built; the o_stat_* ports are tied to 0.
// TESTING
//  1. Hit: src=0x01, lookup hit port=0x04, 3-beat pkt, tready=1 -> 3 beats out,
//     beat1 dst=0x04, rd pulses once each, fwd=1.
//  2. Miss: src=0x04, hit=0 drop=0 -> dst=0x08, payload bit-exact, cpu=1.
//  3. Drop: drop=1, 5-beat pkt -> 5 FIFO pops, m_axis_tvalid stays 0, drop=1, back to WAIT.
//  4. From CPU: from_cpu=1, tuser dst=0x10, hit port=0x01 -> dst stays 0x10.
//     Lookup entry still popped.
//  5. Backpressure: 1-beat pkt, tready low 4 cycles -> beat held stable, single pop on
//     accept, next pkt decided at earliest 1 cycle later.
//  6. Reset asserted mid-SEND -> next cycle tvalid=0, rd_en=0, state WAIT, counters 0.

Source files
------------

// File: rtl/pkt_decision_ctrl.sv
// pkt_decision_ctrl
//   Per-packet forwarding sequencer for the output-port-lookup path. Pairs the
//   pktstate FIFO head (from-CPU flag) with the lookup-result FIFO head, then
//   decides whether to forward, punt to the CPU, or drop. It then either streams
//   the buffered packet to the master AXIS port, with the tuser dst-port field
//   rewritten on the first beat, or discards the packet.
//
//   Optional feature macro: DECISION_STATS_EN. When it is defined, the three
//   32-bit decision counters are built. Otherwise the o_stat_* ports are tied
//   to 0.
//
// Ports
//   clk, reset                    clock, synchronous active-high reset
//   i_pktstate_valid              pktstate FIFO not empty
//   i_pkt_is_from_cpu             pktstate head: packet came from a CPU port
//   o_rd_pktstate                 pop pulse to pktstate FIFO
//   i_lookup_valid                lookup-result FIFO not empty
//   i_lookup_hit                  lookup head: route/ARP hit
//   i_lookup_drop                 lookup head: drop request
//   i_lookup_port                 lookup head: one-hot egress port
//   o_rd_lookup                   pop pulse to lookup-result FIFO
//   i_fifo_empty                  packet FIFO (fallthrough) empty
//   i_fifo_tdata/tkeep/tuser/tlast  packet FIFO head beat
//   o_fifo_rd_en                  pop one beat from packet FIFO
//   m_axis_*                      egress AXI-stream master
//   o_stat_fwd/cpu/drop           decision counters
//
// States
//   state | meaning
//   WAIT  | idle; pair the pktstate/lookup heads with the packet and decide
//   SEND  | stream the current packet to m_axis
//   DROP  | pop and discard the current packet
module pkt_decision_ctrl #(
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int SRC_PORT_OFF         = 16,
  parameter int DST_PORT_OFF         = 24
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              i_pktstate_valid,
  input  logic                              i_pkt_is_from_cpu,
  output logic                              o_rd_pktstate,
  input  logic                              i_lookup_valid,
  input  logic                              i_lookup_hit,
  input  logic                              i_lookup_drop,
  input  logic [7:0]                        i_lookup_port,
  output logic                              o_rd_lookup,
  input  logic                              i_fifo_empty,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    i_fifo_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  i_fifo_tkeep,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   i_fifo_tuser,
  input  logic                              i_fifo_tlast,
  output logic                              o_fifo_rd_en,
  output logic [C_S_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
  output logic [C_S_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                              m_axis_tlast,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic [31:0]                       o_stat_fwd,
  output logic [31:0]                       o_stat_cpu,
  output logic [31:0]                       o_stat_drop
);

  typedef enum logic [1:0] {WAIT, SEND, DROP} state_t;

  state_t     state, state_nxt;
  logic       go;
  logic [7:0] src;
  logic [7:0] dst_q, dst_d;
  logic       rewrite_q, rewrite_d;
  logic       first_q;
  logic       dec_fwd, dec_cpu, dec_drop;

  // All three heads must be present. The miss path needs the src field from
  // the packet's first beat.
  assign go  = i_pktstate_valid & i_lookup_valid & ~i_fifo_empty;
  assign src = i_fifo_tuser[SRC_PORT_OFF +: 8];

  always_comb begin
    dec_fwd   = 1'b0;
    dec_cpu   = 1'b0;
    dec_drop  = 1'b0;
    dst_d     = dst_q;
    rewrite_d = 1'b0;
    if (i_pkt_is_from_cpu) begin
      dec_fwd = 1'b1;
    end else if (i_lookup_drop || (i_lookup_hit && i_lookup_port == 8'h00)) begin
      dec_drop = 1'b1;
    end else if (i_lookup_hit) begin
      dec_fwd   = 1'b1;
      dst_d     = i_lookup_port;
      rewrite_d = 1'b1;
    end else begin
      // CPU ports sit on the odd bits, paired with the MAC ports on the even bits.
      dec_cpu   = 1'b1;
      dst_d     = src << 1;
      rewrite_d = 1'b1;
    end
  end

  // state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= WAIT;
      dst_q     <= 8'h00;
      rewrite_q <= 1'b0;
      first_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == WAIT && go) begin
        dst_q     <= dst_d;
        rewrite_q <= rewrite_d;
        first_q   <= 1'b1;
      end else if (state == SEND && o_fifo_rd_en) begin
        first_q <= 1'b0;
      end
    end
  end

  // next state
  always_comb begin
    state_nxt = state;
    case (state)
      WAIT: if (go) state_nxt = dec_drop ? DROP : SEND;
      SEND: if (m_axis_tvalid && m_axis_tready && i_fifo_tlast) state_nxt = WAIT;
      DROP: if (!i_fifo_empty && i_fifo_tlast) state_nxt = WAIT;
      default: state_nxt = WAIT;
    endcase
  end

  // outputs
  always_comb begin
    o_rd_pktstate = 1'b0;
    o_rd_lookup   = 1'b0;
    o_fifo_rd_en  = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tuser  = i_fifo_tuser;
    case (state)
      WAIT: begin
        o_rd_pktstate = go;
        o_rd_lookup   = go;
      end
      SEND: begin
        m_axis_tvalid = ~i_fifo_empty;
        o_fifo_rd_en  = ~i_fifo_empty & m_axis_tready;
        if (first_q && rewrite_q) m_axis_tuser[DST_PORT_OFF +: 8] = dst_q;
      end
      DROP: o_fifo_rd_en = ~i_fifo_empty;
      default: ;
    endcase
  end

  assign m_axis_tdata = i_fifo_tdata;
  assign m_axis_tkeep = i_fifo_tkeep;
  assign m_axis_tlast = i_fifo_tlast;

`ifdef DECISION_STATS_EN
  logic [31:0] stat_fwd, stat_cpu, stat_drop;

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_fwd  <= 32'd0;
      stat_cpu  <= 32'd0;
      stat_drop <= 32'd0;
    end else if (state == WAIT && go) begin
      if (dec_fwd)  stat_fwd  <= stat_fwd + 32'd1;
      if (dec_cpu)  stat_cpu  <= stat_cpu + 32'd1;
      if (dec_drop) stat_drop <= stat_drop + 32'd1;
    end
  end

  assign o_stat_fwd  = stat_fwd;
  assign o_stat_cpu  = stat_cpu;
  assign o_stat_drop = stat_drop;
`else
  assign o_stat_fwd  = 32'd0;
  assign o_stat_cpu  = 32'd0;
  assign o_stat_drop = 32'd0;
`endif

endmodule
